// File: rtl/demux4_collector.sv
// ---------------------------------------------------------------------------
// demux4_collector
//
// Routes a serial bit stream to one of four channels selected by {m,s} and
// assembles WIDTH-bit words per channel. Each accepted beat also produces a
// one-cycle pulse on the selected channel's demux output. When a channel
// collects its WIDTH-th bit, the finished word is presented on a
// valid/ready output port together with the channel code.
//
// Channel code {m,s}: 00 -> b, 01 -> a, 10 -> c, 11 -> d (out_ch uses it too)
//
// Ports
//   clk        in   system clock, all state changes on rising edge
//   rst        in   synchronous active-high reset
//   din        in   serial data bit
//   m, s       in   channel select (upper, lower)
//   in_valid   in   din/m/s carry a beat this cycle
//   in_ready   out  beat can be accepted (low while a word is pending)
//   wa..wd     out  registered one-cycle demux pulses
//   out_valid  out  assembled word available
//   out_ready  in   consumer takes the word this cycle
//   out_data   out  assembled word, first received bit at the MSB
//   out_ch     out  channel code of out_data
// ---------------------------------------------------------------------------
module demux4_collector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             m,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wa,
    output logic             wb,
    output logic             wc,
    output logic             wd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Per-channel state is indexed directly by the {m,s} code.
    logic [WIDTH-1:0] shreg [4];
    logic [CW-1:0]    cnt   [4];

    logic [1:0]       sel;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign sel      = {m, s};
    // Only one word can be pending, so input is stalled while it is held.
    assign in_ready = ~out_valid;
    assign accept   = in_valid & in_ready;
    assign shifted  = {shreg[sel][WIDTH-2:0], din};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shreg[i] <= '0;
                cnt[i]   <= '0;
            end
            wa        <= 1'b0;
            wb        <= 1'b0;
            wc        <= 1'b0;
            wd        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= 2'b00;
        end else begin
            // Demux pulses default low so each beat gives a single-cycle pulse.
            wa <= accept & (sel == 2'b01) & din;
            wb <= accept & (sel == 2'b00) & din;
            wc <= accept & (sel == 2'b10) & din;
            wd <= accept & (sel == 2'b11) & din;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A beat is never accepted while out_valid is high, so the
            // completion below cannot collide with the handshake above.
            if (accept) begin
                if (cnt[sel] == LAST) begin
                    out_data   <= shifted;
                    out_ch     <= sel;
                    out_valid  <= 1'b1;
                    shreg[sel] <= '0;
                    cnt[sel]   <= '0;
                end else begin
                    shreg[sel] <= shifted;
                    cnt[sel]   <= cnt[sel] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_demux4_collector.sv
// ---------------------------------------------------------------------------
// tb_demux4_collector
//
// Directed bench for demux4_collector with WIDTH=4. Each task drives one
// scenario and compares outputs against hand-computed values.
// Inputs change 1 ns after the rising edge; outputs are read at that point.
// ---------------------------------------------------------------------------
module tb_demux4_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       m = 1'b0;
    logic       s = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       wa, wb, wc, wd;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [1:0] out_ch;

    int checks = 0;
    int failures = 0;

    demux4_collector #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .m         (m),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wa        (wa),
        .wb        (wb),
        .wc        (wc),
        .wd        (wd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    // Expected {wa,wb,wc,wd} for a beat on channel code with data bit b.
    function automatic logic [3:0] exp_w(input logic [1:0] code, input logic b);
        logic [3:0] onehot;
        case (code)
            2'b01:   onehot = 4'b1000;
            2'b00:   onehot = 4'b0100;
            2'b10:   onehot = 4'b0010;
            default: onehot = 4'b0001;
        endcase
        return b ? onehot : 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted-or-offered beat lasting a single cycle.
    task automatic beat(input logic [1:0] code, input logic b);
        m = code[1];
        s = code[0];
        din = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        din = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready_during: got %b want 1", in_ready);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({wa, wb, wc, wd} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_w: got %b want 0000", {wa, wb, wc, wd});
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_out_data: got %b want 0000", out_data);
        end
        checks++;
        if (out_ch !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_out_ch: got %b want 00", out_ch);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        // out_ready with nothing pending must do nothing.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_out_ready: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_single_channel();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset(1);
        for (int i = 3; i >= 0; i--) begin
            beat(2'b01, bits[i]);
            checks++;
            if ({wa, wb, wc, wd} !== exp_w(2'b01, bits[i])) begin
                failures++;
                $display("[TB] FAIL single_w beat%0d: got %b want %b", 3 - i, {wa, wb, wc, wd}, exp_w(2'b01, bits[i]));
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL single_early_valid beat%0d: got %b want 0", 3 - i, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_ch !== 2'b01) begin
            failures++;
            $display("[TB] FAIL single_word: got v=%b d=%b ch=%b want v=1 d=1011 ch=01", out_valid, out_data, out_ch);
        end
        tick();
        checks++;
        if ({wa, wb, wc, wd} !== 4'b0000 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_idle: got w=%b v=%b want w=0000 v=1", {wa, wb, wc, wd}, out_valid);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_drain: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_interleave();
        logic [1:0] codes [7];
        logic       vals  [7];
        codes = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
        vals  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            beat(codes[i], vals[i]);
            checks++;
            if ({wa, wb, wc, wd} !== exp_w(codes[i], vals[i])) begin
                failures++;
                $display("[TB] FAIL interleave_w beat%0d: got %b want %b", i, {wa, wb, wc, wd}, exp_w(codes[i], vals[i]));
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1101 || out_ch !== 2'b00) begin
            failures++;
            $display("[TB] FAIL interleave_word_b: got v=%b d=%b ch=%b want v=1 d=1101 ch=00", out_valid, out_data, out_ch);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL interleave_drain: out_valid got %b want 0", out_valid);
        end
        beat(2'b10, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0110 || out_ch !== 2'b10) begin
            failures++;
            $display("[TB] FAIL interleave_word_c: got v=%b d=%b ch=%b want v=1 d=0110 ch=10", out_valid, out_data, out_ch);
        end
    endtask

    // Runs with the channel-c word from test_interleave still pending.
    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(2'b11, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'b0110 || out_ch !== 2'b10 || in_ready !== 1'b0 || wd !== 1'b0) begin
                failures++;
                $display("[TB] FAIL backpressure_hold cyc%0d: got v=%b d=%b ch=%b rdy=%b wd=%b want v=1 d=0110 ch=10 rdy=0 wd=0",
                         i, out_valid, out_data, out_ch, in_ready, wd);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        // Channel d must still be empty: the word completes on the 4th beat.
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b0);
        beat(2'b11, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_d_count: out_valid got %b want 0", out_valid);
        end
        beat(2'b11, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1001 || out_ch !== 2'b11) begin
            failures++;
            $display("[TB] FAIL backpressure_d_word: got v=%b d=%b ch=%b want v=1 d=1001 ch=11", out_valid, out_data, out_ch);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b1);
        do_reset(1);
        beat(2'b11, 1'b0);
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_early: out_valid got %b want 0", out_valid);
        end
        beat(2'b11, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0110 || out_ch !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reset_mid_word: got v=%b d=%b ch=%b want v=1 d=0110 ch=11", out_valid, out_data, out_ch);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_priority();
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b0);
        beat(2'b11, 1'b1);
        rst = 1'b1;
        beat(2'b11, 1'b1);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'b0000 || wd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_priority: got v=%b d=%b wd=%b want v=0 d=0000 wd=0", out_valid, out_data, wd);
        end
        // Count must be back at 0: three more beats must not complete.
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b1);
        beat(2'b11, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_priority_count: out_valid got %b want 0", out_valid);
        end
        beat(2'b11, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1100 || out_ch !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reset_priority_word: got v=%b d=%b ch=%b want v=1 d=1100 ch=11", out_valid, out_data, out_ch);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_channel();
        test_interleave();
        test_backpressure();
        test_reset_mid_word();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux4_collector.md
DEMUX4_COLLECTOR -- requirements
Module: demux4_collector

Interface
REQ-001 Parameter: WIDTH, 4, bits collected per channel before a word is emitted (legal range 2..16).
REQ-002 Clocking: one clock; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 din  input  1  serial data bit to be routed.
REQ-006 m  input  1  select, upper bit.
REQ-007 s  input  1  select, lower bit.
REQ-008 in_valid  input  1  din/m/s qualify a beat this cycle.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 wa, wb, wc, wd  output  1 each  registered per-channel demux outputs.
REQ-011 out_valid  output  1  assembled word available.
REQ-012 out_ready  input  1  consumer takes the word this cycle.
REQ-013 out_data  output  WIDTH  assembled word.
REQ-014 out_ch  output  2  source channel code of out_data.

Function
REQ-015 Channel decode from {m,s}: 00 selects b, 01 selects a, 10 selects c, 11 selects d. This is the inverse of the team's 4:1 selector mapping. out_ch carries this same 2-bit code.
REQ-016 A beat is accepted when in_valid=1 and in_ready=1. No state changes on cycles without an accepted beat, except the output handshake.
REQ-017 in_ready SHALL equal ~out_valid (combinational).
REQ-018 Demux outputs: on an accepted beat, the selected w* register takes din and the other three take 0. On cycles with no accepted beat, all four take 0, giving a one-cycle pulse per beat.
REQ-019 Each channel has an independent WIDTH-bit shift register and a counter that counts 0..WIDTH-1.
REQ-020 Shift rule: the new bit enters the LSB and existing bits shift toward the MSB, so the first received bit ends at the MSB.
REQ-021 Accepted beat with selected count < WIDTH-1: shift in din and increment that channel's count. Other channels are unchanged.
REQ-022 Accepted beat with selected count = WIDTH-1 (completion), on the next edge:
- out_data = {shreg[WIDTH-2:0], din}
- out_ch = channel code
- out_valid = 1
- that channel's count and shift register are cleared to 0.
REQ-023 Latency: out_valid asserts exactly 1 cycle after the completing beat.
REQ-024 While out_valid=1, out_data and out_ch SHALL remain stable until the edge where out_ready=1. out_valid then clears on that edge.
REQ-025 out_ready while out_valid=0 has no effect.
REQ-026 in_valid while in_ready=0 is ignored:
- no shift, no count change
- all w* outputs = 0.
REQ-027 At most one word is pending; REQ-017 guarantees no completion can occur while a word is pending.
REQ-028 Best-case throughput is one word per WIDTH+1 cycles per channel when out_ready is held at 1.
REQ-029 Partial channel contents persist indefinitely; there is no timeout or flush.

Reset
REQ-030 With rst=1 at an edge, the following SHALL be 0: all shift registers, all counts, wa..wd, out_valid, out_data, out_ch.
REQ-031 rst SHALL take priority over any beat or handshake in the same cycle, and partial words SHALL be discarded.
REQ-032 While rst=1, in_ready SHALL read 1, since out_valid=0.

Verification (WIDTH=4)
REQ-033 Reset: rst=1 for 2 cycles, then check outputs -> wa..wd=0, out_valid=0, out_data=0000, out_ch=00, in_ready=1.
REQ-034 Single channel: {m,s}=01, din=1,0,1,1 on 4 consecutive accepted beats ->
- wa pulses 1,0,1,1 and wb/wc/wd stay 0
- 1 cycle after the 4th beat: out_valid=1, out_data=1011, out_ch=01.
REQ-035 Interleave:
- Beats: b:1, c:0, b:1, c:1, b:0, c:1, b:1, c:0.
- Expected: word 1101 with out_ch=00 after the 7th beat, pulsed out with out_ready=1; then word 0110 with out_ch=10 after the 8th beat.
REQ-036 Backpressure:
- After completion, hold out_ready=0 for 5 cycles and drive in_valid=1 to channel d with din=1.
- Expected: out_valid, out_data and out_ch stable; in_ready=0; wd=0; d count unchanged.
- Then raise out_ready for 1 cycle: out_valid=0 and in_ready=1 on the next cycle.
REQ-037 Reset mid-word:
- Drive 3 beats to d (1,1,1), assert rst for 1 cycle, then drive 0,1,1,0 to d.
- Expected: out_data=0110, out_ch=11, with no residue from the earlier beats.
REQ-038 Reset priority: assert rst in the same cycle as a completing beat -> out_valid stays 0 and the channel count is 0.
